scmp_alu_mc: RTL and testbench
==============================

SCMP_ALU_MC -- requirements
Module: scmp_alu_mc

Interface
REQ-001 SHALL have parameter W, default 8, datapath width; legal values are 8, 16, 24 and 32.
REQ-002 SHALL have parameter DIGITS, default W/4, the BCD digit count; it is derived and not overridden.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port op_i, input, ALU_MC_OP_t: the operation select.
REQ-007 SHALL have ports A_i and B_i, input, W bits each: the operands.
REQ-008 SHALL have ports Cy_i and Ov_i, input, 1 bit each: incoming carry/link and overflow flags.
REQ-009 SHALL have port busy_o, output, 1 bit: high while a multi-cycle operation runs.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle pulse when results are valid.
REQ-011 SHALL have port res_o, output, W bits: main result (product low half, or quotient).
REQ-012 SHALL have port ext_o, output, W bits: extension result (product high half, or remainder); zero for other ops.
REQ-013 SHALL have ports Cy_o, HCy_o, Ov_o and divz_o, output, 1 bit each: carry, half (digit-0) carry, overflow and divide-by-zero flags.

Function
REQ-014 SHALL register all outputs; res_o, ext_o and the flags hold their value until the next done_o.
REQ-015 SHALL run a state machine IDLE -> RUN -> FIN -> IDLE; single-cycle ops go IDLE -> FIN.
REQ-016 SHALL complete AND, OR, XOR, ADD, DAD, RRL, INC, DEC and NUL with latency 1: start_i at edge n gives done_o in cycle n+1; busy_o stays low.
REQ-017 SHALL compute ADD as A+B+Cy_i; HCy_o is the bit-3 carry, Cy_o the bit-W carry, Ov_o the signed overflow (operands same sign, result sign differs).
REQ-018 SHALL compute DAD as a BCD add with Cy_i into digit 0: each digit whose binary sum exceeds 9 gets +6 and carries; HCy_o = digit-0 carry, Cy_o = top-digit carry, Ov_o = Ov_i.
REQ-019 SHALL compute RRL as {Cy_i, A}: res_o = {Cy_i, A[W-1:1]}, Cy_o = A[0].
REQ-020 SHALL compute INC and DEC as A±1, with Cy_o as the bit-W carry or borrow.
REQ-021 SHALL pass B through as NUL; logic ops leave Cy_o and Ov_o equal to Cy_i and Ov_i.
REQ-022 SHALL implement MUL as unsigned W×W shift-add, one bit per cycle; busy_o is high for W cycles, done_o follows in cycle W+1, and {ext_o,res_o} is the 2W-bit product; Cy_o = (ext_o != 0).
REQ-023 SHALL implement DIV as unsigned restoring division, one bit per cycle with the same timing as MUL; res_o = quotient, ext_o = remainder.
REQ-024 SHALL finish DIV with B=0 at latency 1 with no RUN phase: res_o all ones, ext_o = A, divz_o = 1.
REQ-025 SHALL clear divz_o on every done_o other than the divide-by-zero case.
REQ-026 SHALL ignore start_i while busy_o or in FIN, without queuing it; op_i, A_i and B_i are captured only at the accepting edge.
REQ-027 SHALL clock the iteration counter down from W-1, with width $clog2(W); RUN exits when it reaches 0.
REQ-028 SHALL gate HCy propagation into the upper digits only, matching the ADD split at bit 3 for all W.

Reset
REQ-029 SHALL on rst_i go immediately to IDLE and set busy_o, done_o, res_o, ext_o and all flags to 0, including mid-RUN; the aborted operation produces no done_o.
REQ-030 SHALL after reset release accept start_i on the first rising edge.

Structure
REQ-031 SHALL declare ALU_MC_OP_t (AND, OR, XOR, ADD, DAD, RRL, INC, DEC, NUL, MUL, DIV) and the state enum in scmp_microcode_pak.
REQ-032 SHALL place the per-digit BCD adder in one sub-module, scmp_bcd_digit (4-bit A, B and carry-in; 4-bit sum and carry-out), instantiated DIGITS times.

Verification
REQ-033 W=8, ADD with A=0x7F, B=0x01, Cy_i=0 SHALL give, 1 cycle later, res=0x80, Ov=1, Cy=0, HCy=1, done pulse.
REQ-034 W=8, DAD with A=0x59, B=0x48, Cy_i=1 SHALL give res=0x08, Cy=1, HCy=1.
REQ-035 W=8, MUL with A=0xFF, B=0xFF SHALL hold busy for 8 cycles, then done at cycle 9 with ext=0xFE, res=0x01, Cy=1.
REQ-036 W=16, DIV with A=1000, B=7 SHALL give res=142, ext=6 at cycle 17; a second start_i mid-RUN is ignored.
REQ-037 W=8, DIV with B=0 and A=0x3C SHALL give res=0xFF, ext=0x3C, divz=1 at latency 1.
REQ-038 rst_i asserted at cycle 4 of a MUL SHALL give busy=0 and all outputs 0 at once, no done_o; a new ADD is accepted next edge after release.

Source files
------------

// File: rtl/scmp_microcode_pak.sv
// Shared types for the SC/MP multi-cycle ALU: operation select and control states.
package scmp_microcode_pak;

    typedef enum logic [3:0] {
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_ADD,
        OP_DAD,
        OP_RRL,
        OP_INC,
        OP_DEC,
        OP_NUL,
        OP_MUL,
        OP_DIV
    } ALU_MC_OP_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } ALU_MC_STATE_t;

    // Divide by zero short-circuits to a single-cycle result.
    function automatic logic is_multi_cycle(input ALU_MC_OP_t op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/scmp_bcd_digit.sv
// One BCD digit adder: binary sum of two digits plus carry, +6 correction above 9.
module scmp_bcd_digit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_sum,
    output logic       o_c
);

    logic [4:0] w_bin;
    logic [3:0] w_adj;

    always_comb begin
        w_bin = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_c};
        w_adj = w_bin[3:0] + 4'd6;
        o_c   = (w_bin > 5'd9);
        o_sum = o_c ? w_adj : w_bin[3:0];
    end

endmodule

// File: rtl/scmp_alu_mc.sv
// SC/MP-style ALU: single-cycle logic/arith/BCD ops plus bit-serial unsigned MUL and DIV.
module scmp_alu_mc
    import scmp_microcode_pak::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = W/4
)(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  ALU_MC_OP_t   op_i,
    input  logic [W-1:0] A_i,
    input  logic [W-1:0] B_i,
    input  logic         Cy_i,
    input  logic         Ov_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] res_o,
    output logic [W-1:0] ext_o,
    output logic         Cy_o,
    output logic         HCy_o,
    output logic         Ov_o,
    output logic         divz_o
);

    localparam int CW = $clog2(W);

    ALU_MC_STATE_t r_state;
    ALU_MC_STATE_t w_state_next;
    logic          w_accept;
    logic          w_last;
    logic          w_b_zero;
    logic          w_multi;

    ALU_MC_OP_t    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_cy_in;
    logic          r_ov_in;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [CW-1:0] r_cnt;

    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_ext;
    logic          r_cy;
    logic          r_hcy;
    logic          r_ov;
    logic          r_divz;

    logic [W:0]    w_add;
    logic [W:0]    w_inc;
    logic [W:0]    w_dec;
    logic [W-1:0]  w_dad;
    logic [DIGITS:0] w_dc;

    logic [W-1:0]  w_sc_res;
    logic [W-1:0]  w_sc_ext;
    logic          w_sc_cy;
    logic          w_sc_hcy;
    logic          w_sc_ov;
    logic          w_sc_divz;

    logic [W:0]    w_mul_sum;
    logic [W:0]    w_div_shift;
    logic [W-1:0]  w_div_diff;
    logic          w_div_ge;
    logic [W-1:0]  w_step_hi;
    logic [W-1:0]  w_step_lo;

    assign w_b_zero = (B_i == '0);
    assign w_multi  = is_multi_cycle(op_i, w_b_zero);

    assign w_add = (W+1)'(A_i) + (W+1)'(B_i) + (W+1)'(Cy_i);
    assign w_inc = (W+1)'(A_i) + (W+1)'(1);
    assign w_dec = (W+1)'(A_i) - (W+1)'(1);

    // Decimal adder: digit carries ripple from Cy_i upward.
    assign w_dc[0] = Cy_i;
    generate
        genvar gi;
        for (gi = 0; gi < DIGITS; gi++) begin : g_bcd
            scmp_bcd_digit u_digit (
                .i_a   (A_i[4*gi +: 4]),
                .i_b   (B_i[4*gi +: 4]),
                .i_c   (w_dc[gi]),
                .o_sum (w_dad[4*gi +: 4]),
                .o_c   (w_dc[gi+1])
            );
        end
    endgenerate

    always_comb begin
        w_sc_res  = '0;
        w_sc_ext  = '0;
        w_sc_cy   = Cy_i;
        w_sc_hcy  = 1'b0;
        w_sc_ov   = Ov_i;
        w_sc_divz = 1'b0;
        case (op_i)
            OP_AND: w_sc_res = A_i & B_i;
            OP_OR:  w_sc_res = A_i | B_i;
            OP_XOR: w_sc_res = A_i ^ B_i;
            OP_ADD: begin
                w_sc_res = w_add[W-1:0];
                w_sc_cy  = w_add[W];
                // Carry into bit 4 recovered from the full sum.
                w_sc_hcy = w_add[4] ^ A_i[4] ^ B_i[4];
                w_sc_ov  = (A_i[W-1] == B_i[W-1]) && (w_add[W-1] != A_i[W-1]);
            end
            OP_DAD: begin
                w_sc_res = w_dad;
                w_sc_cy  = w_dc[DIGITS];
                w_sc_hcy = w_dc[1];
            end
            OP_RRL: begin
                w_sc_res = {Cy_i, A_i[W-1:1]};
                w_sc_cy  = A_i[0];
            end
            OP_INC: begin
                w_sc_res = w_inc[W-1:0];
                w_sc_cy  = w_inc[W];
            end
            OP_DEC: begin
                w_sc_res = w_dec[W-1:0];
                w_sc_cy  = w_dec[W];
            end
            OP_NUL: w_sc_res = B_i;
            OP_DIV: begin
                w_sc_res  = '1;
                w_sc_ext  = A_i;
                w_sc_divz = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide on {r_hi, r_lo}.
    assign w_mul_sum   = (W+1)'(r_hi) + (r_lo[0] ? (W+1)'(r_a) : (W+1)'(0));
    assign w_div_shift = {r_hi, r_lo[W-1]};
    assign w_div_ge    = (w_div_shift >= (W+1)'(r_b));
    assign w_div_diff  = w_div_shift[W-1:0] - r_b;

    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_op == OP_MUL) begin
            w_step_hi = w_mul_sum[W:1];
            w_step_lo = {w_mul_sum[0], r_lo[W-1:1]};
        end else begin
            w_step_hi = w_div_ge ? w_div_diff : w_div_shift[W-1:0];
            w_step_lo = {r_lo[W-2:0], w_div_ge};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_accept     = 1'b1;
                    w_state_next = w_multi ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_last       = 1'b1;
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op    <= OP_AND;
            r_a     <= '0;
            r_b     <= '0;
            r_cy_in <= 1'b0;
            r_ov_in <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
            r_ext   <= '0;
            r_cy    <= 1'b0;
            r_hcy   <= 1'b0;
            r_ov    <= 1'b0;
            r_divz  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            r_done <= (w_state_next == ST_FIN);
            if (w_accept) begin
                r_op    <= op_i;
                r_a     <= A_i;
                r_b     <= B_i;
                r_cy_in <= Cy_i;
                r_ov_in <= Ov_i;
                r_hi    <= '0;
                r_lo    <= (op_i == OP_MUL) ? B_i : A_i;
                r_cnt   <= CW'(W-1);
                if (!w_multi) begin
                    r_res  <= w_sc_res;
                    r_ext  <= w_sc_ext;
                    r_cy   <= w_sc_cy;
                    r_hcy  <= w_sc_hcy;
                    r_ov   <= w_sc_ov;
                    r_divz <= w_sc_divz;
                end
            end else if (r_state == ST_RUN) begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_res  <= w_step_lo;
                    r_ext  <= w_step_hi;
                    r_cy   <= (r_op == OP_MUL) ? (w_step_hi != '0) : r_cy_in;
                    r_hcy  <= 1'b0;
                    r_ov   <= r_ov_in;
                    r_divz <= 1'b0;
                end
            end
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign res_o  = r_res;
    assign ext_o  = r_ext;
    assign Cy_o   = r_cy;
    assign HCy_o  = r_hcy;
    assign Ov_o   = r_ov;
    assign divz_o = r_divz;

endmodule

// File: tb/tb_scmp_alu_mc.sv
// Self-checking bench for scmp_alu_mc: W=8 instance for most scenarios, W=16 for the long divide.
module tb_scmp_alu_mc;
    import scmp_microcode_pak::*;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] ext;
        logic        cy;
        logic        hcy;
        logic        ov;
        logic        divz;
    } out_t;

    logic        clk;
    logic        rst;

    logic        start8;
    ALU_MC_OP_t  op8;
    logic [7:0]  a8, b8;
    logic        cy8, ov8;
    logic        busy8, done8;
    logic [7:0]  res8, ext8;
    logic        cyo8, hcyo8, ovo8, divz8;

    logic        start16;
    ALU_MC_OP_t  op16;
    logic [15:0] a16, b16;
    logic        cy16, ov16;
    logic        busy16, done16;
    logic [15:0] res16, ext16;
    logic        cyo16, hcyo16, ovo16, divz16;

    int   n_checks = 0;
    int   n_pass   = 0;
    out_t q8[$];

    scmp_alu_mc #(.W(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op8), .A_i(a8), .B_i(b8),
        .Cy_i(cy8), .Ov_i(ov8), .busy_o(busy8), .done_o(done8), .res_o(res8), .ext_o(ext8),
        .Cy_o(cyo8), .HCy_o(hcyo8), .Ov_o(ovo8), .divz_o(divz8)
    );

    scmp_alu_mc #(.W(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .op_i(op16), .A_i(a16), .B_i(b16),
        .Cy_i(cy16), .Ov_i(ov16), .busy_o(busy16), .done_o(done16), .res_o(res16), .ext_o(ext16),
        .Cy_o(cyo16), .HCy_o(hcyo16), .Ov_o(ovo16), .divz_o(divz16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic out_t obs8();
        return {32'(res8), 32'(ext8), cyo8, hcyo8, ovo8, divz8};
    endfunction

    // Behavioural reference written with wide integer arithmetic.
    function automatic out_t model(input int w, input ALU_MC_OP_t op,
                                   input longint unsigned a, input longint unsigned b,
                                   input logic cy, input logic ov);
        out_t r;
        longint unsigned mask, s, x, c, acc;
        mask = (64'd1 << w) - 64'd1;
        r = '0;
        r.cy = cy;
        r.ov = ov;
        case (op)
            OP_AND: r.res = 32'(a & b);
            OP_OR:  r.res = 32'(a | b);
            OP_XOR: r.res = 32'(a ^ b);
            OP_ADD: begin
                s = a + b + 64'(cy);
                r.res = 32'(s & mask);
                r.cy  = ((s >> w) & 64'd1) != 0;
                r.hcy = ((a & 64'd15) + (b & 64'd15) + 64'(cy)) > 64'd15;
                r.ov  = (((a >> (w-1)) & 1) == ((b >> (w-1)) & 1)) &&
                        (((s >> (w-1)) & 1) != ((a >> (w-1)) & 1));
            end
            OP_DAD: begin
                c = 64'(cy);
                acc = 0;
                for (int d = 0; d < w/4; d++) begin
                    x = ((a >> (4*d)) & 64'd15) + ((b >> (4*d)) & 64'd15) + c;
                    if (x > 9) begin
                        x = x + 6;
                        c = 1;
                    end else begin
                        c = 0;
                    end
                    acc = acc | ((x & 64'd15) << (4*d));
                    if (d == 0) r.hcy = (c != 0);
                end
                r.res = 32'(acc);
                r.cy  = (c != 0);
            end
            OP_RRL: begin
                r.res = 32'((64'(cy) << (w-1)) | (a >> 1));
                r.cy  = (a & 64'd1) != 0;
            end
            OP_INC: begin
                s = a + 1;
                r.res = 32'(s & mask);
                r.cy  = ((s >> w) & 64'd1) != 0;
            end
            OP_DEC: begin
                r.res = 32'((a - 1) & mask);
                r.cy  = (a == 0);
            end
            OP_NUL: r.res = 32'(b);
            OP_MUL: begin
                s = a * b;
                r.res = 32'(s & mask);
                r.ext = 32'(s >> w);
                r.cy  = (s >> w) != 0;
            end
            OP_DIV: begin
                if (b == 0) begin
                    r.res  = 32'(mask);
                    r.ext  = 32'(a);
                    r.divz = 1'b1;
                end else begin
                    r.res = 32'(a / b);
                    r.ext = 32'(a % b);
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic issue8(input ALU_MC_OP_t op, input logic [7:0] a, input logic [7:0] b,
                          input logic cy, input logic ov);
        op8 = op; a8 = a; b8 = b; cy8 = cy; ov8 = ov;
        start8 = 1'b1;
        q8.push_back(model(8, op, 64'(a), 64'(b), cy, ov));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Latency 1 means done_o is already high right after the accepting edge.
    task automatic wait8(output out_t obs, output int lat, output int nbusy);
        lat = 1;
        nbusy = 0;
        while (!done8 && lat < 100) begin
            if (busy8) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        obs = obs8();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, res8, ext8, cyo8, hcyo8, ovo8, divz8} !== '0)
            $display("FAIL reset8: got busy=%b done=%b res=%h ext=%h flags=%b%b%b%b want all 0",
                     busy8, done8, res8, ext8, cyo8, hcyo8, ovo8, divz8);
        else n_pass++;
        n_checks++;
        if ({busy16, done16, res16, ext16, cyo16, hcyo16, ovo16, divz16} !== '0)
            $display("FAIL reset16: got busy=%b done=%b res=%h ext=%h want all 0",
                     busy16, done16, res16, ext16);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_add();
        out_t obs, exp, want;
        int lat, nb;
        issue8(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait8(obs, lat, nb);
        exp = q8.pop_front();
        want = '0;
        want.res = 32'h80; want.ov = 1'b1; want.hcy = 1'b1;
        n_checks++;
        if (obs !== want) $display("FAIL add_7f_01: got %h want %h", obs, want); else n_pass++;
        n_checks++;
        if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat); else n_pass++;
        n_checks++;
        if (nb !== 0) $display("FAIL add_busy: got %0d busy cycles want 0", nb); else n_pass++;
        n_checks++;
        if (done8 !== 1'b0 || obs8() !== obs)
            $display("FAIL add_pulse_hold: done=%b out=%h want done=0 out=%h", done8, obs8(), obs);
        else n_pass++;
        $display("add 7f+01: res=%h flags cy=%b hcy=%b ov=%b (model %h)", obs.res[7:0], obs.cy, obs.hcy, obs.ov, exp.res[7:0]);
    endtask

    task automatic test_dad();
        out_t obs, exp, want;
        int lat, nb;
        issue8(OP_DAD, 8'h59, 8'h48, 1'b1, 1'b1);
        wait8(obs, lat, nb);
        exp = q8.pop_front();
        want = '0;
        want.res = 32'h08; want.cy = 1'b1; want.hcy = 1'b1; want.ov = 1'b1;
        n_checks++;
        if (obs !== want || lat !== 1) $display("FAIL dad_59_48: got %h lat %0d want %h lat 1", obs, lat, want);
        else n_pass++;
        $display("dad 59+48+1: res=%h cy=%b hcy=%b (model %h)", obs.res[7:0], obs.cy, obs.hcy, exp.res[7:0]);
    endtask

    task automatic test_single_ops();
        ALU_MC_OP_t ops [9];
        out_t obs, exp;
        int lat, nb;
        logic [7:0] a, b;
        logic cy, ov;
        ops = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_DAD, OP_RRL, OP_INC, OP_DEC, OP_NUL};
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 9; i++) begin
                if (p == 0)      begin a = 8'h00; b = 8'hA5; cy = 1'b1; ov = 1'b0; end
                else if (p == 1) begin a = 8'hFF; b = 8'h5A; cy = 1'b0; ov = 1'b1; end
                else begin
                    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
                    cy = 1'($urandom_range(0, 1)); ov = 1'($urandom_range(0, 1));
                end
                issue8(ops[i], a, b, cy, ov);
                wait8(obs, lat, nb);
                exp = q8.pop_front();
                n_checks++;
                if (obs !== exp || lat !== 1 || nb !== 0)
                    $display("FAIL single_%s a=%h b=%h: got %h lat %0d busy %0d want %h lat 1 busy 0",
                             ops[i].name(), a, b, obs, lat, nb, exp);
                else n_pass++;
                $display("%s a=%h b=%h cy=%b: res=%h cy=%b", ops[i].name(), a, b, cy, obs.res[7:0], obs.cy);
            end
        end
    endtask

    task automatic test_mul();
        out_t obs, exp, want;
        int lat, nb;
        issue8(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        wait8(obs, lat, nb);
        exp = q8.pop_front();
        want = '0;
        want.res = 32'h01; want.ext = 32'hFE; want.cy = 1'b1;
        n_checks++;
        if (obs !== want) $display("FAIL mul_ff_ff: got %h want %h", obs, want); else n_pass++;
        n_checks++;
        if (lat !== 9 || nb !== 8) $display("FAIL mul_timing: got lat %0d busy %0d want lat 9 busy 8", lat, nb);
        else n_pass++;
        $display("mul ff*ff: ext=%h res=%h lat=%0d (model %h%h)", obs.ext[7:0], obs.res[7:0], lat, exp.ext[7:0], exp.res[7:0]);
    endtask

    task automatic test_divz();
        out_t obs, exp, want;
        int lat, nb;
        issue8(OP_DIV, 8'h3C, 8'h00, 1'b0, 1'b0);
        wait8(obs, lat, nb);
        exp = q8.pop_front();
        want = '0;
        want.res = 32'hFF; want.ext = 32'h3C; want.divz = 1'b1;
        n_checks++;
        if (obs !== want || lat !== 1 || nb !== 0)
            $display("FAIL divz_3c: got %h lat %0d busy %0d want %h lat 1 busy 0", obs, lat, nb, want);
        else n_pass++;
        $display("div 3c/0: res=%h ext=%h divz=%b", obs.res[7:0], obs.ext[7:0], obs.divz);
        issue8(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0);
        wait8(obs, lat, nb);
        exp = q8.pop_front();
        n_checks++;
        if (obs !== exp || obs.divz !== 1'b0) $display("FAIL divz_clear: got %h want %h", obs, exp);
        else n_pass++;
        $display("add 01+02 after div0: res=%h divz=%b", obs.res[7:0], obs.divz);
    endtask

    task automatic test_div16_ignore_start();
        int lat, extra;
        op16 = OP_DIV; a16 = 16'd1000; b16 = 16'd7; cy16 = 1'b0; ov16 = 1'b0;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 100) begin
            if (lat == 5) begin
                start16 = 1'b1; op16 = OP_ADD; a16 = 16'h1111; b16 = 16'h2222;
            end else begin
                start16 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start16 = 1'b0;
        n_checks++;
        if (res16 !== 16'd142 || ext16 !== 16'd6 || divz16 !== 1'b0)
            $display("FAIL div16_1000_7: got res=%0d ext=%0d divz=%b want res=142 ext=6 divz=0", res16, ext16, divz16);
        else n_pass++;
        n_checks++;
        if (lat !== 17) $display("FAIL div16_latency: got %0d want 17", lat); else n_pass++;
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done16) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL div16_queued_start: got %0d extra done want 0", extra); else n_pass++;
        $display("div16 1000/7: res=%0d ext=%0d lat=%0d", res16, ext16, lat);
    endtask

    task automatic test_fin_ignore();
        out_t exp;
        int extra;
        issue8(OP_XOR, 8'h0F, 8'hF0, 1'b0, 1'b0);
        exp = q8.pop_front();
        n_checks++;
        if (done8 !== 1'b1) $display("FAIL fin_done: got %b want 1", done8); else n_pass++;
        start8 = 1'b1; op8 = OP_NUL; b8 = 8'h77;
        @(posedge clk); #1;
        start8 = 1'b0;
        extra = 0;
        repeat (3) begin
            if (done8) extra++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (extra !== 0 || res8 !== exp.res[7:0])
            $display("FAIL fin_ignore: got %0d done pulses res=%h want 0 pulses res=%h", extra, res8, exp.res[7:0]);
        else n_pass++;
        $display("xor 0f^f0 with start in FIN: res=%h", res8);
    endtask

    task automatic test_reset_mid_run();
        out_t obs, exp;
        int lat, nb;
        issue8(OP_MUL, 8'hFF, 8'hFF, 1'b1, 1'b1);
        exp = q8.pop_front();
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy8 !== 1'b1) $display("FAIL mul_busy_cycle4: got %b want 1", busy8); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, res8, ext8, cyo8, hcyo8, ovo8, divz8} !== '0)
            $display("FAIL reset_mid_run: got busy=%b done=%b res=%h ext=%h flags=%b%b%b%b want all 0",
                     busy8, done8, res8, ext8, cyo8, hcyo8, ovo8, divz8);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0)
            $display("FAIL reset_no_done: got done=%b busy=%b want 0 0", done8, busy8);
        else n_pass++;
        issue8(OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0);
        wait8(obs, lat, nb);
        exp = q8.pop_front();
        n_checks++;
        if (obs !== exp || lat !== 1) $display("FAIL add_after_reset: got %h lat %0d want %h lat 1", obs, lat, exp);
        else n_pass++;
        $display("add 12+34 after reset: res=%h lat=%0d", obs.res[7:0], lat);
    endtask

    task automatic test_back_to_back();
        out_t obs, exp;
        int lat, nb, want_lat;
        ALU_MC_OP_t op;
        logic [7:0] a, b;
        logic cy, ov;
        for (int i = 0; i < 40; i++) begin
            op = ALU_MC_OP_t'($urandom_range(0, 10));
            a  = 8'($urandom_range(0, 255));
            b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cy = 1'($urandom_range(0, 1));
            ov = 1'($urandom_range(0, 1));
            want_lat = (op == OP_MUL || (op == OP_DIV && b != 0)) ? 9 : 1;
            issue8(op, a, b, cy, ov);
            wait8(obs, lat, nb);
            exp = q8.pop_front();
            n_checks++;
            if (obs !== exp || lat !== want_lat)
                $display("FAIL rand_%0d_%s a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, op.name(), a, b, obs, lat, exp, want_lat);
            else n_pass++;
            $display("rand %0d %s a=%h b=%h: res=%h ext=%h lat=%0d", i, op.name(), a, b, obs.res[7:0], obs.ext[7:0], lat);
        end
    endtask

    initial begin
        rst = 1'b0;
        start8 = 1'b0; op8 = OP_AND; a8 = '0; b8 = '0; cy8 = 1'b0; ov8 = 1'b0;
        start16 = 1'b0; op16 = OP_AND; a16 = '0; b16 = '0; cy16 = 1'b0; ov16 = 1'b0;
        #2 rst = 1'b1;
        test_reset();
        test_add();
        test_dad();
        test_single_ops();
        test_mul();
        test_divz();
        test_div16_ignore_start();
        test_fin_ignore();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
